// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                       |
// | Description : Shared datapath width, reset PC and address type.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int                 WIDTH    = 16;
    localparam logic [WIDTH-1:0]   RESET_PC = 16'h0000;

    typedef logic [WIDTH-1:0] addr_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : return_addr_stack                                             |
// | Description : Small LIFO of return addresses. Pop has priority over push   |
// |               when both are requested; overflow pushes are dropped.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module return_addr_stack #(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    import cpu_pkg::*;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Count runs 0..DEPTH, so it needs one bit more than an entry index.
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic               w_do_push;
    logic               w_do_pop;

    // When full the low count bits wrap to 0, so top-1 still lands on DEPTH-1.
    assign w_wr_idx  = r_count[c_PTR_W-1:0];
    assign w_top_idx = r_count[c_PTR_W-1:0] - c_PTR_W'(1);

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign top_data  = r_mem[w_top_idx];

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & ~pop & ~full;
    assign overflow  = push & ~pop & full;
    assign underflow = pop & empty;

    // Occupancy counter; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_pop) begin
            r_count <= r_count - c_CNT_W'(1);
        end else if (w_do_push) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Entry storage; contents beyond the count are don't-care.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule : return_addr_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_unit                                                       |
// | Description : Program counter with next-PC priority mux, PC-relative       |
// |               branch, absolute jump, call/return via return stack, and a   |
// |               sticky stack error flag.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_unit #(
    parameter int               WIDTH       = cpu_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter int               STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] r_pc;
    logic             r_stack_err;
    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_top_data;
    logic             w_push;
    logic             w_pop;
    logic             w_overflow;
    logic             w_underflow;

    assign w_pc_seq = r_pc + WIDTH'(1);

    // Ret beats call, so a simultaneous call never pushes; stall and reset
    // keep the stack untouched by the control inputs.
    assign w_pop  = ret & ~stall & ~rst;
    assign w_push = call & ~ret & ~stall & ~rst;

    return_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_seq),
        .top_data  (w_top_data),
        .full      (stack_full),
        .empty     (stack_empty),
        .overflow  (w_overflow),
        .underflow (w_underflow)
    );

    // Next-PC priority mux: rst > stall > ret > call > jump > branch > seq.
    always_comb begin
        w_pc_next = w_pc_seq;
        if (rst) begin
            w_pc_next = RESET_PC;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (ret) begin
            w_pc_next = stack_empty ? w_pc_seq : w_top_data;
        end else if (call || jump) begin
            w_pc_next = jump_target;
        end else if (branch_taken) begin
            w_pc_next = w_pc_seq + offset;
        end
    end

    // PC register; the mux already folds in reset and stall.
    always_ff @(posedge clk) begin
        r_pc <= w_pc_next;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stack_err <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_stack_err <= 1'b1;
        end
    end

    assign pc        = r_pc;
    assign pc_next   = w_pc_next;
    assign stack_err = r_stack_err;

endmodule : pc_unit
`default_nettype wire
